vermibus_arbiter: RTL
=====================

VERMIBUS_ARBITER -- requirements
Module: vermibus_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = alternate grants between requesters and 0 = fixed priority to m0.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles a granted transfer waits for s.ready; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port m0  Vermibus.s  interface  requester 0 (higher priority when ROUND_ROBIN=0).
REQ-006 SHALL have port m1  Vermibus.s  interface  requester 1.
REQ-007 SHALL have port s  Vermibus.m  interface  shared downstream bus.
REQ-008 SHALL have port timeout  output  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-009 SHALL implement three states: IDLE, GRANT0, GRANT1.
REQ-010 In IDLE: s.valid=0; s.address, s.wstrobe and s.wdata=0; m0.ready and m1.ready=0.
REQ-011 In IDLE with exactly one of m0.valid, m1.valid high, SHALL go next cycle to the matching GRANTn state.
REQ-012 In IDLE with both valid and ROUND_ROBIN=1, SHALL grant the requester not served last; with ROUND_ROBIN=0, SHALL grant m0.
REQ-013 In GRANTn: s.valid, s.address, s.wstrobe and s.wdata SHALL equal mn's signals combinationally; the other requester's ready=0.
REQ-014 In GRANTn: mn.ready=s.ready and mn.rdata=s.rdata, both combinational, with zero added latency.
REQ-015 In GRANTn with s.ready=1 (s.valid high): SHALL record n as last served and return to IDLE next cycle.
- Minimum spacing between two grants is therefore 2 cycles: one handshake cycle plus one IDLE cycle.
REQ-016 In GRANTn with mn.valid=0 (requester withdrew): SHALL return to IDLE next cycle without updating last served.
REQ-017 A wait counter SHALL clear on entry to GRANTn and increment each GRANTn cycle without s.ready.
REQ-018 When TIMEOUT>0 and the counter equals TIMEOUT without s.ready:
- assert mn.ready=1 with mn.rdata=0 for that cycle;
- pulse timeout=1 for that cycle;
- record n as last served;
- return to IDLE.
REQ-019 The wait counter SHALL be $clog2(TIMEOUT+1) bits wide, minimum 1, and SHALL saturate rather than wrap when TIMEOUT=0.
REQ-020 m0.rdata and m1.rdata SHALL be 0 whenever that requester is not granted.
REQ-021 m0.irq and m1.irq SHALL both equal s.irq combinationally in all states.
REQ-022 s.ready arriving while s.valid=0 SHALL be ignored.

Reset
REQ-023 reset low SHALL asynchronously force:
- state=IDLE;
- wait counter=0;
- last served=m1, so that m0 wins the first tie;
- timeout=0, plus the IDLE output values of REQ-010.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer silently; no ready is returned to the requester after reset.

Verification
REQ-025 Single request: m0 reads address 0x100; slave returns ready after 3 cycles with rdata 0xDEADBEEF -> s.valid high 1 cycle after m0.valid; m0 sees ready with 0xDEADBEEF; m1.ready stays 0.
REQ-026 Simultaneous requests, ROUND_ROBIN=1, zero-wait slave, both held for 4 transfers -> grant order m0, m1, m0, m1; each grant 2 cycles apart.
REQ-027 Simultaneous requests, ROUND_ROBIN=0 -> m0 granted every time while it requests; m1 granted only in the first IDLE in which m0.valid=0.
REQ-028 TIMEOUT=4, slave never ready, m1 writes wstrobe 4'b0011 -> on the 4th GRANT1 cycle m1.ready=1, m1.rdata=0, timeout=1 for one cycle; next cycle IDLE.
REQ-029 Reset low during GRANT0 with the slave stalled -> s.valid=0 and m0.ready=0 immediately; after release, a tie grants m0.
REQ-030 s.irq toggled in each state -> m0.irq and m1.irq track it in the same cycle.

Source files
------------

// File: rtl/vermibus_arbiter_if.sv
// rtl/vermibus_arbiter_if.sv - Vermibus requester/completer bus interface
interface Vermibus;
  logic        valid;
  logic        ready;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport m (output valid, address, wstrobe, wdata, input ready, rdata, irq);
  modport s (input valid, address, wstrobe, wdata, output ready, rdata, irq);
endinterface

// File: rtl/vermibus_arbiter.sv
// rtl/vermibus_arbiter.sv - two-requester Vermibus arbiter with round-robin/fixed priority and wait timeout
module vermibus_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic clk,
  input  logic reset,
  Vermibus.s   m0,
  Vermibus.s   m1,
  Vermibus.m   s,
  output logic timeout
);

  localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit            TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          last;
  logic          gnt0;
  logic          gnt1;
  logic          cur_valid;
  logic          handshake;
  logic          expire;

  assign gnt0      = (state == GRANT0);
  assign gnt1      = (state == GRANT1);
  assign cur_valid = (gnt0 & m0.valid) | (gnt1 & m1.valid);
  assign handshake = cur_valid & s.ready;
  // wait_cnt holds completed stall cycles, so LIMIT marks the TIMEOUT-th stalled cycle
  assign expire    = TO_EN & cur_valid & ~s.ready & (wait_cnt == LIMIT);

  assign s.valid   = cur_valid;
  assign s.address = gnt0 ? m0.address : (gnt1 ? m1.address : '0);
  assign s.wstrobe = gnt0 ? m0.wstrobe : (gnt1 ? m1.wstrobe : '0);
  assign s.wdata   = gnt0 ? m0.wdata   : (gnt1 ? m1.wdata   : '0);

  assign m0.ready  = gnt0 & m0.valid & (s.ready | expire);
  assign m1.ready  = gnt1 & m1.valid & (s.ready | expire);
  assign m0.rdata  = (gnt0 & ~expire) ? s.rdata : '0;
  assign m1.rdata  = (gnt1 & ~expire) ? s.rdata : '0;
  assign m0.irq    = s.irq;
  assign m1.irq    = s.irq;
  assign timeout   = expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      last     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (m0.valid && m1.valid) begin
            state <= (ROUND_ROBIN != 0 && last == 1'b0) ? GRANT1 : GRANT0;
          end else if (m0.valid) begin
            state <= GRANT0;
          end else if (m1.valid) begin
            state <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          if (handshake || expire) begin
            state <= IDLE;
            last  <= gnt1;
          end else if (!cur_valid) begin
            state <= IDLE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
